// File: rtl/spm_arbiter.sv
`timescale 1ns/1ps
// spm_arbiter: shares one serial-parallel multiplier (SPM) core between two
// requesters. A job latches X/Y, clears the core for one cycle, streams Y
// LSB-first into the core for 65 cycles while collecting the serial product,
// then presents the 64-bit result until the consumer accepts it.
// Build option: define SPM_ARBITER_RR_EN for round-robin arbitration;
// left undefined, requester 0 has fixed priority.
module spm_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*WIDTH-1:0]   req_x_i,
  input  logic [2*WIDTH-1:0]   req_y_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_id_o,
  output logic [2*WIDTH-1:0]   resp_p_o,
  output logic                 spm_rst_o,
  output logic [WIDTH-1:0]     spm_x_o,
  output logic                 spm_y_o,
  input  logic                 spm_p_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  localparam int              CNT_W    = $clog2(2*WIDTH + 1);
  localparam int              IDX_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*WIDTH);
  localparam logic [CNT_W-1:0] Y_CNT    = CNT_W'(WIDTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_p;
  logic               r_id;

  logic               w_grant_idx;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_x;
  logic [WIDTH-1:0]   w_sel_y;

`ifdef SPM_ARBITER_RR_EN
  logic r_ptr;

  // Round-robin: the pointer names the preferred requester; it wins if valid.
  always_comb begin
    w_grant_idx = req_valid_i[r_ptr] ? r_ptr : ~r_ptr;
  end

  // After each accept, prefer the requester that was not just served.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_grant_idx;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    w_grant_idx = ~req_valid_i[0];
  end
`endif

  assign w_grant  = (|req_valid_i) ? (2'b01 << w_grant_idx) : 2'b00;
  assign w_accept = (r_state == S_IDLE) && (|req_valid_i);
  assign w_sel_x  = w_grant_idx ? req_x_i[2*WIDTH-1:WIDTH] : req_x_i[WIDTH-1:0];
  assign w_sel_y  = w_grant_idx ? req_y_i[2*WIDTH-1:WIDTH] : req_y_i[WIDTH-1:0];

  // State register; reset returns to IDLE and abandons any job in flight.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of block ordering.
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic for the IDLE -> CLEAR -> RUN -> DONE job sequence.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned,
    // so no latch is inferred for the next state.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)             w_next_state = S_CLEAR;
      S_CLEAR:                           w_next_state = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT)    w_next_state = S_DONE;
      S_DONE:  if (resp_ready_i)         w_next_state = S_IDLE;
      default:                           w_next_state = S_IDLE;
    endcase
  end

  // Per-state outputs; reset forces the core clear and blocks any grant.
  always_comb begin
    req_ready_o  = 2'b00;
    resp_valid_o = 1'b0;
    busy_o       = 1'b1;
    spm_rst_o    = 1'b0;
    spm_y_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = w_grant;
      end
      S_CLEAR: spm_rst_o = 1'b1;
      S_RUN:   if (r_cnt < Y_CNT) spm_y_o = r_y[r_cnt[IDX_W-1:0]];
      S_DONE:  resp_valid_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
    if (!wb_rst_ni) begin
      req_ready_o = 2'b00;
      spm_rst_o   = 1'b1;
    end
  end

  // Job datapath: latch operands on accept, count RUN cycles, and shift the
  // serial product in MSB-first so the first collected bit ends up at bit 0.
  // The core's output lags its input by one cycle, hence no capture at cnt 0.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_cnt <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_p   <= '0;
      r_id  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x  <= w_sel_x;
            r_y  <= w_sel_y;
            r_id <= w_grant_idx;
          end
        end
        S_CLEAR: r_cnt <= '0;
        S_RUN: begin
          if (r_cnt != '0) r_p <= {spm_p_i, r_p[2*WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign spm_x_o   = r_x;
  assign resp_p_o  = r_p;
  assign resp_id_o = r_id;

endmodule
